hex_display_scan: RTL and testbench

HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

---
 rtl/hex_display_scan.sv | 152 +++++++++++++++
 tb/tb_hex_display_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// Multiplexed 4-digit hex display scanner.
// A producer loads a 16-bit value through a ready/valid handshake into a
// pending register. The value only reaches the display register at a frame
// boundary (DIG3 -> DIG0), so a frame never shows a mix of two values.
// Each digit stays active for REFRESH_CYCLES clocks. digit_o and anode_o are
// registered and reload together whenever the slot changes.
module hex_display_scan #(
  parameter int REFRESH_CYCLES = 100000,
  parameter int NUM_DIGITS     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [4*NUM_DIGITS-1:0]   value_i,
  input  logic                      value_valid_i,
  output logic                      value_ready_o,
  input  logic                      lz_suppress_i,
  input  logic                      blank_i,
  output logic [3:0]                digit_o,
  output logic [NUM_DIGITS-1:0]     anode_o,
  output logic                      frame_done_o
);

  localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [1:0]                w_sel_next;
  logic [CNT_W-1:0]          r_refresh;
  logic                      w_wrap;
  logic                      w_boundary;
  logic                      w_transfer;
  logic                      w_promote;
  logic                      r_alive;
  logic [4*NUM_DIGITS-1:0]   r_pending;
  logic                      r_pending_full;
  logic [4*NUM_DIGITS-1:0]   r_display;
  logic [4*NUM_DIGITS-1:0]   w_display_next;
  logic [3:0]                w_nibble [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]     w_hide;
  logic [NUM_DIGITS-1:0]     w_anode_next;
  logic [3:0]                w_digit_next;
  logic [NUM_DIGITS-1:0]     r_anode;
  logic [3:0]                r_digit;

  assign w_wrap     = (r_refresh == CNT_LAST);
  assign w_boundary = w_wrap && (r_state == DIG3);
  // Ready stays low through reset and until the first clock edge after it.
  assign value_ready_o = r_alive && !r_pending_full;
  assign w_transfer    = value_valid_i && value_ready_o;
  assign w_promote     = w_boundary && r_pending_full;
  // Value that the display register will hold after this edge; the output
  // registers reload from it so a new frame starts with the new value.
  assign w_display_next = w_promote ? r_pending : r_display;

  // Marks that at least one clock edge has passed since reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_alive <= 1'b0;
    else         r_alive <= 1'b1;
  end

  // Refresh counter: 0..REFRESH_CYCLES-1 then wrap, one slot per wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_refresh <= '0;
    else if (w_wrap) r_refresh <= '0;
    else             r_refresh <= r_refresh + 1'b1;
  end

  // Scan state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= DIG0;
    else         r_state <= w_state_next;
  end

  // Scan next-state: advance one digit on every counter wrap.
  always_comb begin
    w_state_next = r_state;
    if (w_wrap) begin
      case (r_state)
        DIG0:    w_state_next = DIG1;
        DIG1:    w_state_next = DIG2;
        DIG2:    w_state_next = DIG3;
        default: w_state_next = DIG0;
      endcase
    end
  end

  assign w_sel_next = w_state_next;

  // Pending register: a transfer fills it; a boundary empties it into display.
  // A transfer can only happen while pending is empty, so a transfer on the
  // boundary edge simply lands in pending and waits for the next boundary.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending      <= '0;
      r_pending_full <= 1'b0;
    end else if (w_transfer) begin
      r_pending      <= value_i;
      r_pending_full <= 1'b1;
    end else if (w_boundary) begin
      r_pending_full <= 1'b0;
    end
  end

  // Display register: only updated at a frame boundary.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_display <= '0;
    else if (w_promote) r_display <= r_pending;
  end

  // Per-digit nibble select and leading-zero blanking for the upcoming slot.
  // Digit 0 is never blanked, so a zero value still shows a single 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_nibble[gi] = w_display_next[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign w_hide[gi] = 1'b0;
      end else begin : g_upper
        assign w_hide[gi] = lz_suppress_i &&
                            (w_display_next[4*NUM_DIGITS-1:4*gi] == '0);
      end
      assign w_anode_next[gi] = !((w_sel_next == 2'(gi)) && !w_hide[gi]);
    end
  endgenerate

  assign w_digit_next = w_nibble[w_sel_next];

  // Output registers reload only when a slot starts (and on the first edge
  // out of reset), so lz_suppress_i changes take effect at the next slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_anode <= '1;
      r_digit <= 4'h0;
    end else if (w_wrap || !r_alive) begin
      r_anode <= w_anode_next;
      r_digit <= w_digit_next;
    end
  end

  assign anode_o      = blank_i ? '1 : r_anode;
  assign digit_o      = r_digit;
  assign frame_done_o = w_boundary;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan with REFRESH_CYCLES=4 (16-cycle frame).
// cyc counts rising edges since reset release; all sampling and driving
// happens on the falling edge that follows edge number cyc.
module tb_hex_display_scan;

  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        lz;
  logic        blank;
  logic [3:0]  digit;
  logic [3:0]  anode;
  logic        frame_done;

  int cyc;
  int n_checks = 0;
  int n_pass   = 0;

  hex_display_scan #(
    .REFRESH_CYCLES(RC),
    .NUM_DIGITS    (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .value_i      (value),
    .value_valid_i(value_valid),
    .value_ready_o(value_ready),
    .lz_suppress_i(lz),
    .blank_i      (blank),
    .digit_o      (digit),
    .anode_o      (anode),
    .frame_done_o (frame_done)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // One line per accepted handshake.
  always @(posedge clk) begin
    if (rst_n && value_valid && value_ready)
      $display("xfer value=%h at edge %0d", value, cyc + 1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h (cyc=%0d t=%0t)", tag, obs, exp, cyc, $time);
  endtask

  function automatic logic [3:0] an(input int s);
    logic [3:0] a;
    a = 4'hF;
    a[s] = 1'b0;
    return a;
  endfunction

  task automatic goto(input int target);
    int guard;
    guard = 0;
    while (cyc < target) begin
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        $display("FAIL goto_timeout: got cyc %0d, want %0d", cyc, target);
        $fatal(1, "bench stalled");
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; value = 16'h0; value_valid = 1'b0; lz = 1'b0; blank = 1'b0;

    // Reset state
    #12;
    check("rst_anode", anode, 4'hF);
    check("rst_ready", value_ready, 1'b0);
    check("rst_digit", digit, 4'h0);
    check("rst_fdone", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset, then load 1234 (lands at the edge-16 boundary)
    goto(1);
    check("first_ready", value_ready, 1'b1);
    check("first_anode", anode, 4'b1110);
    check("first_digit", digit, 4'h0);
    value_valid = 1'b1; value = 16'h1234;
    goto(2);
    value_valid = 1'b0;
    check("load_ready_low", value_ready, 1'b0);
    goto(14); check("fdone_14", frame_done, 1'b0);
    goto(15); check("fdone_15", frame_done, 1'b1);
    check("old_digit_15", digit, 4'h0);
    goto(16); check("ready_back_16", value_ready, 1'b1);

    // Scan sequence over one full frame of 1234
    for (int c = 16; c < 32; c++) begin
      goto(c);
      check("scan_anode", anode, an((c % 16) / 4));
      check("scan_digit", digit, 4'(4 - (c % 16) / 4));
      check("scan_fdone", frame_done, (c == 31) ? 1'b1 : 1'b0);
    end

    // Tear-free update and backpressure
    goto(33); value_valid = 1'b1; value = 16'hABCD;
    goto(34); check("tf_ready_low", value_ready, 1'b0);
    value = 16'h5555;
    goto(36); check("tf_old_d1", digit, 4'h3); check("tf_an_d1", anode, 4'b1101);
    goto(40); check("tf_old_d2", digit, 4'h2);
    goto(47); check("tf_old_d3", digit, 4'h1); check("tf_ready_47", value_ready, 1'b0);
    goto(48); check("tf_new_d0", digit, 4'hD); check("tf_an_d0", anode, 4'b1110);
    check("tf_ready_48", value_ready, 1'b1);
    goto(49); check("tf_second_acc", value_ready, 1'b0);
    value_valid = 1'b0;
    goto(52); check("tf_new_d1", digit, 4'hC);
    goto(56); check("tf_new_d2", digit, 4'hB);
    goto(60); check("tf_new_d3", digit, 4'hA);
    goto(64); check("tf_second_shown", digit, 4'h5); check("tf_ready_64", value_ready, 1'b1);

    // Boundary collision: valid exactly on the edge-80 boundary
    goto(79); check("col_fdone_79", frame_done, 1'b1);
    value_valid = 1'b1; value = 16'h9876;
    goto(80); value_valid = 1'b0;
    check("col_ready", value_ready, 1'b0);
    check("col_fdone_80", frame_done, 1'b0);
    check("col_not_shown", digit, 4'h5);
    goto(84); check("col_not_shown_d1", digit, 4'h5);
    goto(94); check("col_fdone_94", frame_done, 1'b0);
    goto(95); check("col_fdone_95", frame_done, 1'b1);
    goto(96); check("col_shown", digit, 4'h6); check("col_ready_96", value_ready, 1'b1);

    // Leading-zero suppression
    lz = 1'b1; value_valid = 1'b1; value = 16'h0005;
    goto(97); value_valid = 1'b0;
    goto(112); check("lz5_an0", anode, 4'b1110); check("lz5_dig", digit, 4'h5);
    value_valid = 1'b1; value = 16'h0000;
    goto(113); value_valid = 1'b0;
    goto(116); check("lz5_an1", anode, 4'hF);
    goto(120); check("lz5_an2", anode, 4'hF);
    goto(124); check("lz5_an3", anode, 4'hF);
    goto(128); check("lz0_an0", anode, 4'b1110); check("lz0_dig", digit, 4'h0);
    value_valid = 1'b1; value = 16'h0100;
    goto(129); value_valid = 1'b0;
    goto(132); check("lz0_an1", anode, 4'hF);
    goto(140); check("lz0_an3", anode, 4'hF);
    goto(144); check("lz100_an0", anode, 4'b1110); check("lz100_d0", digit, 4'h0);
    goto(148); check("lz100_an1", anode, 4'b1101); check("lz100_d1", digit, 4'h0);
    goto(152); check("lz100_an2", anode, 4'b1011); check("lz100_d2", digit, 4'h1);
    goto(156); check("lz100_an3", anode, 4'hF);
    // Clearing lz mid-slot only affects later slots
    goto(157); lz = 1'b0;
    goto(158); check("lz_midslot", anode, 4'hF);
    goto(172); check("lz_off_an3", anode, 4'b0111); check("lz_off_d3", digit, 4'h0);

    // Blanking for one frame
    goto(175); blank = 1'b1; #1;
    check("blk_immediate", anode, 4'hF);
    goto(176); check("blk_176", anode, 4'hF);
    goto(184); check("blk_184", anode, 4'hF);
    goto(191); check("blk_fdone", frame_done, 1'b1); check("blk_191", anode, 4'hF);
    blank = 1'b0; #1;
    check("blk_release", anode, 4'b0111);
    goto(192); check("blk_phase0", anode, 4'b1110); check("blk_d0", digit, 4'h0);
    goto(196); check("blk_phase1", anode, 4'b1101);
    goto(200); check("blk_phase2", anode, 4'b1011); check("blk_d2", digit, 4'h1);

    // Asynchronous reset mid-slot with pending full
    value_valid = 1'b1; value = 16'hFFFF;
    goto(201); value_valid = 1'b0;
    check("ar_pending_full", value_ready, 1'b0);
    goto(202); #2;
    rst_n = 1'b0; #1;
    check("ar_anode", anode, 4'hF);
    check("ar_ready", value_ready, 1'b0);
    check("ar_digit", digit, 4'h0);
    check("ar_fdone", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(1);
    check("ar_rel_anode", anode, 4'b1110);
    check("ar_rel_digit", digit, 4'h0);
    check("ar_rel_ready", value_ready, 1'b1);
    goto(16); check("ar_discard_d0", digit, 4'h0); check("ar_ready_16", value_ready, 1'b1);
    goto(20); check("ar_discard_d1", digit, 4'h0); check("ar_an_20", anode, 4'b1101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
